tlc_farm_sensor: RTL and testbench
==================================

Name: tlc_farm_sensor

Overview:
Farm-road vehicle detector and request generator. It produces the sensor request that the traffic-light controller consumes, and watches that controller's farm-road light outputs to know when the request has been served. It synchronises and debounces the raw inductive-loop signal, counts waiting cars, and holds the request until farm green is shown. After service it enforces a hold-off before it can request again. It sits between the loop pad input and the controller's sensor input.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples (>=1) needed before car_present changes
HOLDOFF_CYCLES, 8, cycles after farm red returns during which no new request is raised (>=1)
CAR_CNT_W, 4, width of the saturating waiting-car counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
ena  in  1  enable; low freezes all state except the synchroniser
loop_raw  in  1  raw, asynchronous, bouncy loop detector
light_farm  in  3  controller farm light, one-hot: 100 red, 010 yellow, 001 green
car_req  out  1  request to controller sensor input
car_present  out  1  debounced loop state
waiting_cnt  out  CAR_CNT_W  cars arrived and not yet served
req_err  out  1  sticky illegal light_farm encoding flag

Behaviour:
- One clock domain. Reset is asynchronous and active-high. Reset forces: sync flops 0, debounce count 0, car_present 0, waiting_cnt 0, req_err 0, holdoff timer 0, FSM IDLE, car_req 0.
- Synchroniser: two flops, loop_raw -> s1 -> loop_s. Always runs, ignores ena.
- Debounce (only when ena=1):
  - Count clears whenever loop_s == car_present.
  - Otherwise count increments.
  - On the edge where the count is DEBOUNCE_CYCLES-1 and the mismatch persists, car_present toggles and the count clears.
  - Latency: a loop_raw level held from edge 0 appears on car_present after edge 2+DEBOUNCE_CYCLES.
- Arrival = the debounce commit edge where car_present goes 0->1. It is an internal one-cycle condition.
- waiting_cnt:
  - +1 on arrival, saturating at 2^CAR_CNT_W-1.
  - Cleared on the REQUEST->SERVED transition.
  - If an arrival coincides with that clear, the result is 1.
- FSM, registered state, evaluated only when ena=1. car_req = (state==REQUEST), decoded from the state register, glitch-free.
  - IDLE: go to REQUEST if waiting_cnt!=0 or arrival this cycle. A car debounced at edge N therefore raises car_req after edge N.
  - REQUEST: hold car_req=1 until light_farm==001, then go to SERVED.
  - SERVED: stay while light_farm is 001 or 010. On light_farm==100, load the timer with HOLDOFF_CYCLES-1 and go to HOLDOFF. Arrivals here still count.
  - HOLDOFF: decrement the timer each cycle. When the timer is 0, go to IDLE. IDLE re-requests on the next edge if waiting_cnt!=0.
- req_err:
  - Set on any edge with ena=1 and light_farm not in {100,010,001}. Cleared only by rst.
  - On the setting edge the FSM goes to IDLE.
  - While req_err=1 the FSM is held in IDLE, so car_req=0. Debounce and waiting_cnt continue.
- ena=0: debounce count, car_present, waiting_cnt, FSM, timer and req_err all hold. The synchroniser keeps sampling, and outputs hold their last values.
- Reset mid-operation: immediate return to reset values and car_req=0, regardless of state or pending cars.
- Bounce: any loop_s pulse shorter than DEBOUNCE_CYCLES cycles never changes car_present.

Test Plan:
1. Assert rst mid-REQUEST with waiting_cnt=2 -> all outputs 0 asynchronously, before the next clk edge. After release, nothing happens until a debounced arrival.
2. Defaults, ena=1, light_farm=100, loop_raw=1 from edge 0:
   - car_present=1, waiting_cnt=1 and car_req=1 after edge 6.
   - Then set light_farm=001 -> next edge car_req=0, waiting_cnt=0, state SERVED.
3. loop_raw high for only 3 cycles (loop_s high 3 cycles) -> car_present, waiting_cnt and car_req stay 0.
4. Arrival while light_farm=001 (SERVED) -> waiting_cnt=1, car_req=0. Then light_farm=100 -> car_req stays 0 for 8 cycles and rises after the 9th edge after red.
5. CAR_CNT_W=2, five clean arrivals with light_farm held 100 -> waiting_cnt saturates at 3, car_req=1 throughout.
6. light_farm=011 with ena=1 -> req_err=1 and car_req=0 after that edge. Both stay so after light_farm returns to 001/100, until rst.
   - Separately, ena=0 with loop_raw toggling cleanly -> car_present, waiting_cnt and car_req all frozen.

Source files
------------

// File: rtl/tlc_farm_sensor_if.sv
// Bundle between the farm-road sensor and the traffic-light controller.
// The sensor drives the request and status. The controller drives the farm light.
interface tlc_farm_sensor_if #(
  parameter int unsigned CAR_CNT_W = 4
) ();
  logic [2:0]           light_farm;
  logic                 car_req;
  logic                 car_present;
  logic [CAR_CNT_W-1:0] waiting_cnt;
  logic                 req_err;

  modport master (
    input  light_farm,
    output car_req, car_present, waiting_cnt, req_err
  );

  modport slave (
    output light_farm,
    input  car_req, car_present, waiting_cnt, req_err
  );
endinterface

// File: rtl/tlc_farm_sensor.sv
// Farm-road loop detector: synchronise, debounce, count waiting cars, and
// hold a request until farm green, then back off before requesting again.
module tlc_farm_sensor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_CYCLES  = 8,
  parameter int unsigned CAR_CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              loop_raw,
  tlc_farm_sensor_if.master bus
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CAR_CNT_W-1:0] CNT_MAX = {CAR_CNT_W{1'b1}};

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {IDLE, REQUEST, SERVED, HOLDOFF} state_e;

  state_e               state_q, state_d;
  logic                 s1_q, s1_d;
  logic                 loop_s_q, loop_s_d;
  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
  logic                 car_present_q, car_present_d;
  logic [CAR_CNT_W-1:0] waiting_cnt_q, waiting_cnt_d;
  logic                 req_err_q, req_err_d;
  logic [HO_W-1:0]      timer_q, timer_d;
  logic                 arrival_c;
  logic                 served_c;
  logic                 light_legal_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      loop_s_q      <= 1'b0;
      db_cnt_q      <= '0;
      car_present_q <= 1'b0;
      waiting_cnt_q <= '0;
      req_err_q     <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      loop_s_q      <= loop_s_d;
      db_cnt_q      <= db_cnt_d;
      car_present_q <= car_present_d;
      waiting_cnt_q <= waiting_cnt_d;
      req_err_q     <= req_err_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    s1_d          = loop_raw;
    loop_s_d      = s1_q;
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    car_present_d = car_present_q;
    waiting_cnt_d = waiting_cnt_q;
    req_err_d     = req_err_q;
    timer_d       = timer_q;
    arrival_c     = 1'b0;
    served_c      = 1'b0;
    light_legal_c = (bus.light_farm == LIGHT_RED) || (bus.light_farm == LIGHT_YELLOW) ||
                    (bus.light_farm == LIGHT_GREEN);

    if (ena) begin
      // Debounce: commit the new level after DEBOUNCE_CYCLES consecutive mismatches
      if (loop_s_q == car_present_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt_d      = '0;
        car_present_d = ~car_present_q;
        arrival_c     = ~car_present_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end

      case (state_q)
        IDLE: begin
          if ((waiting_cnt_q != '0) || arrival_c) state_d = REQUEST;
        end
        REQUEST: begin
          if (bus.light_farm == LIGHT_GREEN) begin
            state_d  = SERVED;
            served_c = 1'b1;
          end
        end
        SERVED: begin
          if (bus.light_farm == LIGHT_RED) begin
            timer_d = HO_W'(HOLDOFF_CYCLES - 1);
            state_d = HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (timer_q == '0) state_d = IDLE;
          else               timer_d = timer_q - HO_W'(1);
        end
        default: state_d = IDLE;
      endcase

      // An illegal light, now or earlier, parks the FSM in IDLE
      if (!light_legal_c || req_err_q) begin
        req_err_d = 1'b1;
        state_d   = IDLE;
        served_c  = 1'b0;
      end

      if (served_c)                                  waiting_cnt_d = arrival_c ? CAR_CNT_W'(1) : '0;
      else if (arrival_c && waiting_cnt_q != CNT_MAX) waiting_cnt_d = waiting_cnt_q + CAR_CNT_W'(1);
    end
  end

  assign bus.car_req     = (state_q == REQUEST);
  assign bus.car_present = car_present_q;
  assign bus.waiting_cnt = waiting_cnt_q;
  assign bus.req_err     = req_err_q;

endmodule

// File: tb/tb_tlc_farm_sensor.sv
// Directed bench for tlc_farm_sensor: default instance plus a 2-bit counter instance.
module tb_tlc_farm_sensor;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic loop_raw;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tlc_farm_sensor_if #(.CAR_CNT_W(4)) ifa ();
  tlc_farm_sensor_if #(.CAR_CNT_W(2)) ifb ();

  tlc_farm_sensor #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .CAR_CNT_W(4)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .loop_raw (loop_raw),
    .bus      (ifa.master)
  );

  tlc_farm_sensor #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8), .CAR_CNT_W(2)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .loop_raw (loop_raw),
    .bus      (ifb.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One clean car: loop high long enough to commit, then low long enough to release
  task automatic car();
    loop_raw = 1'b1;
    tick(8);
    loop_raw = 1'b0;
    tick(8);
  endtask

  initial begin
    rst            = 1'b1;
    ena            = 1'b1;
    loop_raw       = 1'b0;
    ifa.light_farm = 3'b100;
    ifb.light_farm = 3'b100;
    tick(2);
    check("rst_car_req", 32'(ifa.car_req), 32'd0);
    check("rst_car_present", 32'(ifa.car_present), 32'd0);
    check("rst_waiting", 32'(ifa.waiting_cnt), 32'd0);
    check("rst_req_err", 32'(ifa.req_err), 32'd0);
    rst = 1'b0;
    tick(3);

    // Latency: loop high from edge 0 commits on edge 6
    loop_raw = 1'b1;
    tick(5);
    check("lat_cp_e5", 32'(ifa.car_present), 32'd0);
    tick(1);
    check("lat_cp_e6", 32'(ifa.car_present), 32'd1);
    check("lat_wait_e6", 32'(ifa.waiting_cnt), 32'd1);
    check("lat_req_e6", 32'(ifa.car_req), 32'd1);
    ifa.light_farm = 3'b001;
    tick(1);
    check("green_req", 32'(ifa.car_req), 32'd0);
    check("green_wait", 32'(ifa.waiting_cnt), 32'd0);

    // Arrival during SERVED, then hold-off after red
    loop_raw = 1'b0;
    tick(8);
    check("release_cp", 32'(ifa.car_present), 32'd0);
    loop_raw = 1'b1;
    tick(6);
    check("served_arr_cp", 32'(ifa.car_present), 32'd1);
    check("served_arr_wait", 32'(ifa.waiting_cnt), 32'd1);
    check("served_arr_req", 32'(ifa.car_req), 32'd0);
    ifa.light_farm = 3'b100;
    tick(1);
    check("holdoff_load_req", 32'(ifa.car_req), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check($sformatf("holdoff_req_%0d", i), 32'(ifa.car_req), 32'd0);
    end
    tick(1);
    check("holdoff_rerequest", 32'(ifa.car_req), 32'd1);
    ifa.light_farm = 3'b001;
    tick(1);
    check("second_serve_wait", 32'(ifa.waiting_cnt), 32'd0);
    ifa.light_farm = 3'b100;
    tick(1);

    // Bounce shorter than the debounce window
    loop_raw = 1'b0;
    tick(16);
    loop_raw = 1'b1;
    tick(3);
    loop_raw = 1'b0;
    tick(10);
    check("bounce_cp", 32'(ifa.car_present), 32'd0);
    check("bounce_wait", 32'(ifa.waiting_cnt), 32'd0);
    check("bounce_req", 32'(ifa.car_req), 32'd0);

    // Asynchronous reset mid-REQUEST with two waiting cars
    car();
    loop_raw = 1'b1;
    tick(8);
    check("pre_rst_wait", 32'(ifa.waiting_cnt), 32'd2);
    check("pre_rst_req", 32'(ifa.car_req), 32'd1);
    check("pre_rst_cp", 32'(ifa.car_present), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 32'(ifa.car_req), 32'd0);
    check("async_rst_wait", 32'(ifa.waiting_cnt), 32'd0);
    check("async_rst_cp", 32'(ifa.car_present), 32'd0);
    check("async_rst_err", 32'(ifa.req_err), 32'd0);
    loop_raw = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("post_rst_req", 32'(ifa.car_req), 32'd0);
    check("post_rst_wait", 32'(ifa.waiting_cnt), 32'd0);

    // Illegal light encoding is sticky and blocks requests
    ifa.light_farm = 3'b011;
    tick(1);
    check("err_set", 32'(ifa.req_err), 32'd1);
    check("err_req", 32'(ifa.car_req), 32'd0);
    ifa.light_farm = 3'b100;
    car();
    check("err_wait_counts", 32'(ifa.waiting_cnt), 32'd1);
    check("err_red_req", 32'(ifa.car_req), 32'd0);
    ifa.light_farm = 3'b001;
    tick(1);
    check("err_sticky", 32'(ifa.req_err), 32'd1);
    check("err_green_req", 32'(ifa.car_req), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("err_cleared", 32'(ifa.req_err), 32'd0);

    // ena=0 freezes everything but the synchroniser
    ena = 1'b0;
    ifa.light_farm = 3'b011;
    tick(2);
    check("frozen_err", 32'(ifa.req_err), 32'd0);
    ifa.light_farm = 3'b100;
    ena = 1'b1;
    car();
    check("pre_freeze_wait", 32'(ifa.waiting_cnt), 32'd1);
    check("pre_freeze_req", 32'(ifa.car_req), 32'd1);
    ena = 1'b0;
    ifa.light_farm = 3'b001;
    car();
    loop_raw = 1'b1;
    tick(8);
    check("frozen_cp", 32'(ifa.car_present), 32'd0);
    check("frozen_wait", 32'(ifa.waiting_cnt), 32'd1);
    check("frozen_req", 32'(ifa.car_req), 32'd1);
    loop_raw = 1'b0;
    ifa.light_farm = 3'b100;
    ena = 1'b1;

    // Saturation with a 2-bit counter
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    for (int k = 1; k <= 5; k++) begin
      car();
      check($sformatf("sat_wait_%0d", k), 32'(ifb.waiting_cnt), (k < 3) ? 32'(k) : 32'd3);
      check($sformatf("sat_req_%0d", k), 32'(ifb.car_req), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
